// File: rtl/rsa_job_scheduler_pkg.sv
// Shared types and constants for the RSA job scheduler: FSM states,
// config-select codes and requester source tags.
package rsa_job_scheduler_pkg;

  localparam int MSG_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] CFG_N = 2'd0;
  localparam logic [1:0] CFG_E = 2'd1;
  localparam logic [1:0] CFG_D = 2'd2;
  localparam logic [1:0] CFG_RSVD = 2'd3;

  localparam logic SRC_ENC = 1'b0;
  localparam logic SRC_DEC = 1'b1;

endpackage

// File: rtl/rsa_job_scheduler_if.sv
// Bundle of config, requester, engine and response signals around the scheduler.
// slave = scheduler side, master = environment side.
interface rsa_job_scheduler_if #(
  parameter int MSG_W = 12
);
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [MSG_W-1:0] cfg_data;
  logic             cfg_err;
  logic             enc_valid;
  logic [MSG_W-1:0] enc_msg;
  logic             enc_ready;
  logic             dec_valid;
  logic [MSG_W-1:0] dec_msg;
  logic             dec_ready;
  logic             eng_start;
  logic [MSG_W-1:0] eng_msg;
  logic [MSG_W-1:0] eng_key;
  logic [MSG_W-1:0] eng_n;
  logic             eng_done;
  logic [MSG_W-1:0] eng_result;
  logic             resp_valid;
  logic             resp_ready;
  logic [MSG_W-1:0] resp_data;
  logic             resp_src;
  logic             resp_err;
  logic             busy;

  modport slave (
    input  cfg_we, cfg_sel, cfg_data, enc_valid, enc_msg, dec_valid, dec_msg,
           eng_done, eng_result, resp_ready,
    output cfg_err, enc_ready, dec_ready, eng_start, eng_msg, eng_key, eng_n,
           resp_valid, resp_data, resp_src, resp_err, busy
  );

  modport master (
    output cfg_we, cfg_sel, cfg_data, enc_valid, enc_msg, dec_valid, dec_msg,
           eng_done, eng_result, resp_ready,
    input  cfg_err, enc_ready, dec_ready, eng_start, eng_msg, eng_key, eng_n,
           resp_valid, resp_data, resp_src, resp_err, busy
  );

endinterface

// File: rtl/rsa_job_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted. gnt[0] = encrypt, gnt[1] = decrypt.
module rr_arb2
  import rsa_job_scheduler_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant selection
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == SRC_DEC) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Shares one modular-exponentiation engine between encrypt and decrypt requesters,
// holding the key set and guarding each job with a watchdog.
module rsa_job_scheduler
  import rsa_job_scheduler_pkg::*;
#(
  parameter int MSG_W   = MSG_W_DEF,
  parameter int TMO_W   = 16,
  parameter int TIMEOUT = 40000
) (
  input logic                clk,
  input logic                rst_n,
  rsa_job_scheduler_if.slave bus
);

  localparam logic [MSG_W-1:0] N_MIN     = MSG_W'(2);
  localparam logic [TMO_W-1:0] WDOG_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_q;
  logic             last_grant_q;
  logic [MSG_W-1:0] n_q, e_q, d_q;
  logic [MSG_W-1:0] job_msg_q, job_key_q, job_n_q;
  logic             job_src_q;
  logic [MSG_W-1:0] resp_data_q;
  logic             resp_src_q, resp_err_q, resp_valid_q;
  logic             eng_start_q, cfg_err_q;
  logic [TMO_W-1:0] wdog_q;
  logic [1:0]       gnt_s;
  logic             grant_s, cfg_ok_s;

  rr_arb2 u_arb (
    .req        ({bus.dec_valid, bus.enc_valid}),
    .last_grant (last_grant_q),
    .en         (state_q == ST_IDLE),
    .gnt        (gnt_s)
  );

  assign grant_s  = |gnt_s;
  assign cfg_ok_s = (state_q == ST_IDLE) && !grant_s && (bus.cfg_sel != CFG_RSVD);

  assign bus.enc_ready  = gnt_s[0];
  assign bus.dec_ready  = gnt_s[1];
  assign bus.cfg_err    = cfg_err_q;
  assign bus.eng_start  = eng_start_q;
  assign bus.eng_msg    = job_msg_q;
  assign bus.eng_key    = job_key_q;
  assign bus.eng_n      = job_n_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_src   = resp_src_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = (state_q != ST_IDLE);

  // Job FSM, key registers and watchdog
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SRC_DEC;
      n_q          <= '0;
      e_q          <= '0;
      d_q          <= '0;
      job_msg_q    <= '0;
      job_key_q    <= '0;
      job_n_q      <= '0;
      job_src_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_src_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      eng_start_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      wdog_q       <= '0;
    end else begin
      eng_start_q <= 1'b0;
      cfg_err_q   <= bus.cfg_we && !cfg_ok_s;
      if (bus.cfg_we && cfg_ok_s) begin
        case (bus.cfg_sel)
          CFG_N:   n_q <= bus.cfg_data;
          CFG_E:   e_q <= bus.cfg_data;
          CFG_D:   d_q <= bus.cfg_data;
          default: n_q <= n_q;
        endcase
      end
      case (state_q)
        ST_IDLE: begin
          if (grant_s) begin
            // Keys are snapshotted here so later config writes cannot disturb the job
            job_src_q    <= gnt_s[1];
            job_msg_q    <= gnt_s[1] ? bus.dec_msg : bus.enc_msg;
            job_key_q    <= gnt_s[1] ? d_q : e_q;
            job_n_q      <= n_q;
            last_grant_q <= gnt_s[1];
            eng_start_q  <= (n_q >= N_MIN);
            state_q      <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          resp_src_q <= job_src_q;
          if (job_n_q < N_MIN) begin
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            wdog_q  <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.eng_done) begin
            resp_data_q  <= bus.eng_result;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (wdog_q == WDOG_LAST) begin
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            wdog_q <= wdog_q + TMO_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Self-checking bench for rsa_job_scheduler: directed scenarios plus randomized
// traffic scored against a behavioural modexp/round-robin model.
module tb_rsa_job_scheduler;
  import rsa_job_scheduler_pkg::*;

  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   eng_lat = 30;
  int   k_n = 0, k_e = 0, k_d = 0;
  logic mdl_last = SRC_DEC;
  logic [11:0] done_key = 12'd0;
  bit   grant_log[$];

  rsa_job_scheduler_if #(.MSG_W(12)) bus ();

  rsa_job_scheduler #(.MSG_W(12), .TMO_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.eng_done) done_key <= bus.eng_key;

  function automatic logic [11:0] modexp(input int unsigned m, input int unsigned k, input int unsigned n);
    longint unsigned r, b;
    if (n < 2) return 12'd0;
    r = 1;
    b = longint'(m % n);
    for (int i = 0; i < 12; i++) begin
      if (k[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return 12'(r);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural engine: answers msg^key mod n eng_lat cycles after eng_start (0 = never)
  initial begin
    int unsigned em, ek, en;
    int lat;
    bus.eng_done = 1'b0;
    bus.eng_result = 12'd0;
    forever begin
      @(negedge clk);
      if (bus.eng_start === 1'b1 && eng_lat > 0) begin
        em = bus.eng_msg; ek = bus.eng_key; en = bus.eng_n; lat = eng_lat;
        repeat (lat) @(posedge clk);
        #1;
        bus.eng_done = 1'b1;
        bus.eng_result = modexp(em, ek, en);
        @(posedge clk);
        #1;
        bus.eng_done = 1'b0;
      end
    end
  end

  task automatic cfg_write(input logic [1:0] sel, input int val, input logic exp_err);
    @(posedge clk); #1;
    bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_data = 12'(val);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    @(negedge clk);
    check_val("cfg_err", bus.cfg_err, exp_err);
    if (!exp_err) begin
      if (sel == CFG_N) k_n = val;
      else if (sel == CFG_E) k_e = val;
      else if (sel == CFG_D) k_d = val;
    end
  endtask

  task automatic run_job(input logic src, input int msg, input int hold);
    int g, s, w;
    int key;
    logic exp_err;
    logic [11:0] exp_data;
    key = (src == SRC_DEC) ? k_d : k_e;
    exp_err = (k_n < 2) || (eng_lat == 0);
    exp_data = exp_err ? 12'd0 : modexp(msg, key, k_n);
    @(posedge clk); #1;
    if (src == SRC_DEC) begin bus.dec_valid = 1'b1; bus.dec_msg = 12'(msg); end
    else begin bus.enc_valid = 1'b1; bus.enc_msg = 12'(msg); end
    @(negedge clk);
    check_val("job_ready", {bus.dec_ready, bus.enc_ready}, (src == SRC_DEC) ? 2 : 1);
    g = cyc; mdl_last = src;
    @(posedge clk); #1;
    bus.enc_valid = 1'b0; bus.dec_valid = 1'b0;
    @(negedge clk);
    check_val("start_after_grant", bus.eng_start, k_n >= 2);
    if (k_n >= 2) begin
      check_val("eng_msg", bus.eng_msg, msg);
      check_val("eng_key", bus.eng_key, key);
      check_val("eng_n", bus.eng_n, k_n);
    end
    s = cyc;
    @(negedge clk);
    check_val("start_pulse", bus.eng_start, 0);
    w = 0;
    while (!bus.resp_valid && w < 300) begin @(negedge clk); w++; end
    check_val("resp_seen", bus.resp_valid, 1);
    if (k_n < 2) check_val("err_lat", cyc - g, 2);
    else if (eng_lat == 0) check_val("tmo_lat", cyc - s, TIMEOUT + 1);
    else begin
      check_val("done_lat", cyc - s, eng_lat + 1);
      check_val("key_in_wait", done_key, key);
    end
    check_val("resp_data", bus.resp_data, exp_data);
    check_val("resp_src", bus.resp_src, src);
    check_val("resp_err", bus.resp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_valid", bus.resp_valid, 1);
      check_val("hold_data", bus.resp_data, exp_data);
      check_val("hold_src", bus.resp_src, src);
      check_val("hold_err", bus.resp_err, exp_err);
    end
    @(posedge clk); #1; bus.resp_ready = 1'b1;
    @(posedge clk); #1; bus.resp_ready = 1'b0;
    @(negedge clk);
    check_val("resp_cleared", bus.resp_valid, 0);
    check_val("idle_after", bus.busy, 0);
  endtask

  // Concurrent requesters with random valid/ready; every accepted job is scored in order
  task automatic traffic(input int n_enc, input int n_dec, input int p_valid, input int p_ready);
    int enc_left, dec_left, resp_left, guard;
    bit enc_g, dec_g;
    logic exp_src;
    int key;
    logic [11:0] dq[$];
    bit sq[$], eq[$];
    enc_left = n_enc; dec_left = n_dec; resp_left = n_enc + n_dec; guard = 0;
    enc_g = 0; dec_g = 0;
    while (resp_left > 0 && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      if (enc_g) begin bus.enc_valid = 1'b0; enc_left--; end
      if (dec_g) begin bus.dec_valid = 1'b0; dec_left--; end
      enc_g = 0; dec_g = 0;
      if (!bus.enc_valid && enc_left > 0 && $urandom_range(99) < p_valid) begin
        bus.enc_valid = 1'b1; bus.enc_msg = 12'($urandom_range(4095));
      end
      if (!bus.dec_valid && dec_left > 0 && $urandom_range(99) < p_valid) begin
        bus.dec_valid = 1'b1; bus.dec_msg = 12'($urandom_range(4095));
      end
      bus.resp_ready = ($urandom_range(99) < p_ready);
      @(negedge clk);
      if (bus.enc_ready || bus.dec_ready) begin
        if (bus.enc_valid && bus.dec_valid) exp_src = ~mdl_last;
        else exp_src = bus.dec_valid;
        check_val("rr_grant", {bus.dec_ready, bus.enc_ready}, exp_src ? 2 : 1);
        mdl_last = exp_src;
        grant_log.push_back(exp_src);
        key = exp_src ? k_d : k_e;
        dq.push_back(modexp(exp_src ? bus.dec_msg : bus.enc_msg, key, k_n));
        sq.push_back(exp_src);
        eq.push_back(k_n < 2);
        if (exp_src) dec_g = 1; else enc_g = 1;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (dq.size() == 0) check_val("unexpected_resp", 1, 0);
        else begin
          check_val("tr_data", bus.resp_data, dq.pop_front());
          check_val("tr_src", bus.resp_src, sq.pop_front());
          check_val("tr_err", bus.resp_err, eq.pop_front());
        end
        resp_left--;
      end
    end
    check_val("traffic_drained", resp_left, 0);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0; bus.enc_valid = 1'b0; bus.dec_valid = 1'b0;
  endtask

  initial begin
    int bad, seen;
    rst_n = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_data = 12'd0;
    bus.enc_valid = 1'b0; bus.enc_msg = 12'd0;
    bus.dec_valid = 1'b0; bus.dec_msg = 12'd0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_resp_valid", bus.resp_valid, 0);
    check_val("rst_eng_start", bus.eng_start, 0);
    check_val("rst_cfg_err", bus.cfg_err, 0);
    check_val("rst_eng_n", bus.eng_n, 0);
    check_val("rst_resp_data", bus.resp_data, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // 1-2: textbook key set, encrypt then decrypt
    cfg_write(CFG_N, 3233, 1'b0);
    cfg_write(CFG_E, 17, 1'b0);
    cfg_write(CFG_D, 2753, 1'b0);
    eng_lat = 30;
    run_job(SRC_ENC, 65, 0);
    check_val("rsa_enc_known", modexp(65, 17, 3233), 2790);
    run_job(SRC_DEC, 2790, 0);

    // 3: both requesters always valid -> strict alternation
    grant_log.delete();
    eng_lat = 5;
    traffic(2, 2, 100, 100);
    check_val("alt_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size(); i++) check_val("alt_order", grant_log[i], i % 2);

    // 4: degenerate modulus
    cfg_write(CFG_N, 1, 1'b0);
    run_job(SRC_ENC, 5, 0);

    // 5: silent engine -> watchdog, response held while not accepted
    cfg_write(CFG_N, 3233, 1'b0);
    eng_lat = 0;
    run_job(SRC_ENC, 65, 10);

    // 7: reserved select and write colliding with a grant are rejected
    cfg_write(CFG_RSVD, 55, 1'b1);
    eng_lat = 8;
    @(posedge clk); #1;
    bus.enc_valid = 1'b1; bus.enc_msg = 12'd65;
    bus.cfg_we = 1'b1; bus.cfg_sel = CFG_E; bus.cfg_data = 12'd99;
    @(posedge clk); #1;
    bus.enc_valid = 1'b0; bus.cfg_we = 1'b0; bus.resp_ready = 1'b1;
    mdl_last = SRC_ENC;
    @(negedge clk);
    check_val("cfg_err_grant", bus.cfg_err, 1);
    bad = 0;
    while (!bus.resp_valid && bad < 300) begin @(negedge clk); bad++; end
    check_val("old_e_used", bus.resp_data, 2790);
    @(posedge clk); #1; bus.resp_ready = 1'b0;

    // 6: config in WAIT rejected, reset mid-job, late eng_done ignored
    eng_lat = 30;
    @(posedge clk); #1; bus.enc_valid = 1'b1; bus.enc_msg = 12'd65;
    @(negedge clk); check_val("t6_ready", bus.enc_ready, 1);
    @(posedge clk); #1; bus.enc_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1; bus.cfg_we = 1'b1; bus.cfg_sel = CFG_N; bus.cfg_data = 12'd77;
    @(posedge clk); #1; bus.cfg_we = 1'b0;
    @(negedge clk);
    check_val("cfg_err_wait", bus.cfg_err, 1);
    check_val("n_unchanged", bus.eng_n, 3233);
    check_val("busy_wait", bus.busy, 1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    k_n = 0; k_e = 0; k_d = 0; mdl_last = SRC_DEC;
    @(negedge clk);
    check_val("rst_mid_busy", bus.busy, 0);
    check_val("rst_mid_eng_n", bus.eng_n, 0);
    bad = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.eng_done) seen = 1;
      if (bus.resp_valid || bus.busy) bad++;
    end
    check_val("late_done_arrived", seen, 1);
    check_val("late_done_ignored", bad, 0);

    // Randomized rounds with fresh key sets
    for (int r = 0; r < 4; r++) begin
      cfg_write(CFG_N, (r == 3) ? 1 : int'($urandom_range(2, 4095)), 1'b0);
      cfg_write(CFG_E, int'($urandom_range(4095)), 1'b0);
      cfg_write(CFG_D, int'($urandom_range(4095)), 1'b0);
      eng_lat = $urandom_range(1, 20);
      traffic(6, 6, 60, 70);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
